// File: rtl/addsub_seq_pkg.sv
// Shared types and opcode encodings for the addsub_seq front-end.
package addsub_seq_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;
endpackage

// File: rtl/addsub_seq_addsub.sv
// Combinational add/subtract datapath; result wraps modulo 2^WIDTH.
module addsub
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             add_sub,
  output logic [WIDTH-1:0] result
);
  always_comb begin
    result = (add_sub == OP_ADD) ? (a + b) : (a - b);
  end
endmodule

// File: rtl/addsub_seq.sv
// Handshaked operand front-end and result/flag capture around addsub,
// with an accumulator for chained operations and a completed-op counter.
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_add_sub,
  input  logic             in_acc,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d, res_q, res_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   ext;

  addsub #(.WIDTH(WIDTH)) u_addsub (
    .a       (a_q),
    .b       (b_q),
    .add_sub (op_q),
    .result  (sum)
  );

  // Extended form exposes carry/borrow in bit WIDTH for the flags.
  always_comb begin
    ext = (op_q == OP_ADD) ? ({1'b0, a_q} + {1'b0, b_q})
                           : ({1'b0, a_q} - {1'b0, b_q});
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    acc_d       = acc_q;
    res_d       = res_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          if (in_clr) begin
            acc_d = '0;
            cnt_d = '0;
          end else begin
            a_d     = in_acc ? acc_q : in_a;
            b_d     = in_b;
            op_d    = in_add_sub;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        res_d   = sum;
        carry_d = (op_q == OP_SUB) ? ~ext[WIDTH] : ext[WIDTH];
        if (op_q == OP_ADD)
          ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ext[WIDTH-1] != a_q[WIDTH-1]);
        else
          ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (ext[WIDTH-1] != a_q[WIDTH-1]);
        zero_d      = (ext[WIDTH-1:0] == '0);
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          acc_d       = res_q;
          cnt_d       = cnt_q + 1'b1;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  // Operand registers only matter once EXEC is reached, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_carry  = carry_q;
  assign out_ovf    = ovf_q;
  assign out_zero   = zero_q;
  assign op_count   = cnt_q;
endmodule

// File: tb/tb_addsub_seq.sv
// Directed self-checking bench for addsub_seq (WIDTH=8, CNT_W=8).
module tb_addsub_seq;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic       in_add_sub, in_acc, in_clr;
  logic       out_valid, out_ready;
  logic [7:0] out_result;
  logic       out_carry, out_ovf, out_zero;
  logic [7:0] op_count;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] r_res;
  logic       r_c, r_o, r_z;
  logic [7:0] held;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_add_sub (in_add_sub),
    .in_acc     (in_acc),
    .in_clr     (in_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero),
    .op_count   (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one transaction, wait (bounded) for the result, capture it, complete handshake.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic add, input logic acc);
    bit seen;
    in_a = a; in_b = b; in_add_sub = add; in_acc = acc; in_clr = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("out_valid_timeout", {31'd0, seen}, 32'd1);
    r_res = out_result; r_c = out_carry; r_o = out_ovf; r_z = out_zero;
    tick();
  endtask

  task automatic check_res(input string tag, input logic [7:0] res,
                           input logic c, input logic o, input logic z);
    chk({tag, "_result"}, {24'd0, r_res}, {24'd0, res});
    chk({tag, "_carry"},  {31'd0, r_c},   {31'd0, c});
    chk({tag, "_ovf"},    {31'd0, r_o},   {31'd0, o});
    chk({tag, "_zero"},   {31'd0, r_z},   {31'd0, z});
  endtask

  task automatic do_clr();
    in_clr = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_add_sub = 1'b0; in_acc = 1'b0; in_clr = 1'b0; out_ready = 1'b1;

    // 1. Reset
    repeat (3) tick();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_op_count",  {24'd0, op_count},  32'd0);
    chk("rst_result",    {24'd0, out_result}, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // 2. Add with explicit latency checks
    in_a = 8'd9; in_b = 8'd2; in_add_sub = 1'b1; in_acc = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("exec_out_valid", {31'd0, out_valid}, 32'd0);
    chk("exec_in_ready",  {31'd0, in_ready},  32'd0);
    tick();
    chk("add_out_valid",  {31'd0, out_valid}, 32'd1);
    chk("add_result",     {24'd0, out_result}, 32'd11);
    chk("add_carry",      {31'd0, out_carry}, 32'd0);
    chk("add_ovf",        {31'd0, out_ovf},   32'd0);
    chk("add_zero",       {31'd0, out_zero},  32'd0);
    tick();
    chk("add_done_valid", {31'd0, out_valid}, 32'd0);
    chk("add_done_ready", {31'd0, in_ready},  32'd1);
    chk("add_op_count",   {24'd0, op_count},  32'd1);

    // 3. Subtract and overflow
    run_op(8'd9, 8'd2, 1'b0, 1'b0);    check_res("sub_9_2", 8'd7, 1'b1, 1'b0, 1'b0);
    run_op(8'd2, 8'd9, 1'b0, 1'b0);    check_res("sub_2_9", 8'd249, 1'b0, 1'b0, 1'b0);
    run_op(8'd127, 8'd1, 1'b1, 1'b0);  check_res("add_ovf", 8'd128, 1'b0, 1'b1, 1'b0);
    run_op(8'd128, 8'd1, 1'b0, 1'b0);  check_res("sub_ovf", 8'd127, 1'b1, 1'b1, 1'b0);
    run_op(8'd255, 8'd1, 1'b1, 1'b0);  check_res("add_wrap", 8'd0, 1'b1, 1'b0, 1'b1);
    chk("cnt_after_ops", {24'd0, op_count}, 32'd6);

    // 4. Accumulate chain
    do_clr();
    chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
    chk("clr_op_count", {24'd0, op_count}, 32'd0);
    run_op(8'd99, 8'd5, 1'b1, 1'b1);   check_res("acc1", 8'd5, 1'b0, 1'b0, 1'b0);
    run_op(8'd99, 8'd5, 1'b1, 1'b1);   check_res("acc2", 8'd10, 1'b0, 1'b0, 1'b0);
    run_op(8'd99, 8'd5, 1'b1, 1'b1);   check_res("acc3", 8'd15, 1'b0, 1'b0, 1'b0);
    run_op(8'd99, 8'd15, 1'b0, 1'b1);  check_res("acc_sub", 8'd0, 1'b1, 1'b0, 1'b1);
    chk("acc_op_count", {24'd0, op_count}, 32'd4);

    // 5. Back-pressure
    out_ready = 1'b0;
    in_a = 8'd200; in_b = 8'd100; in_add_sub = 1'b1; in_acc = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    held = out_result;
    chk("bp_result", {24'd0, held}, 32'd44);
    chk("bp_carry",  {31'd0, out_carry}, 32'd1);
    in_a = 8'd7; in_b = 8'd7; in_add_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_stable",   {24'd0, out_result}, {24'd0, held});
      chk("bp_valid",    {31'd0, out_valid},  32'd1);
      chk("bp_in_ready", {31'd0, in_ready},   32'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_done_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_done_ready", {31'd0, in_ready},  32'd1);
    chk("bp_op_count",   {24'd0, op_count},  32'd5);
    run_op(8'd0, 8'd0, 1'b1, 1'b1);    check_res("bp_acc", 8'd44, 1'b0, 1'b0, 1'b0);

    // 6a. Reset during EXEC
    in_a = 8'd0; in_b = 8'd1; in_add_sub = 1'b1; in_acc = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid",  {31'd0, out_valid},  32'd0);
    chk("mid_rst_ready",  {31'd0, in_ready},   32'd0);
    chk("mid_rst_count",  {24'd0, op_count},   32'd0);
    chk("mid_rst_result", {24'd0, out_result}, 32'd0);
    #2;
    reset = 1'b1;
    tick();
    chk("post_rst_ready", {31'd0, in_ready},  32'd1);
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    run_op(8'd50, 8'd3, 1'b1, 1'b1);   check_res("post_rst_acc", 8'd3, 1'b0, 1'b0, 1'b0);

    // 6b. Counter wrap
    do_clr();
    for (int i = 0; i < 256; i++) begin
      run_op(8'd1, 8'd1, 1'b1, 1'b0);
      if (i == 254) chk("cnt_255", {24'd0, op_count}, 32'd255);
    end
    chk("cnt_wrap", {24'd0, op_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
